// File: rtl/key_load_pkg.sv
// ============================================================================
// key_load_pkg : shared types and constants for the key loader
// Rev 1.0
// ============================================================================
`default_nettype none

package key_load_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SHIFT   = 2'd1,
      ST_CHECK   = 2'd2,
      ST_LOCKOUT = 2'd3
   } state_e;

   localparam int KEY_W_DEF = 12;

   // A frame is the key bits followed by one even-parity bit.
   function automatic int frame_len(input int key_w);
      return key_w + 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/key_shift_reg.sv
// ============================================================================
// key_shift_reg : indexed key bit capture with running parity and clear
// Rev 1.0
// ============================================================================
`default_nettype none

module key_shift_reg #(
   parameter int KEY_W = 12,
   parameter int IDX_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             capture,
   input  logic [IDX_W-1:0] idx,
   input  logic             bit_in,
   output logic [KEY_W-1:0] data,
   output logic             parity
);

   logic [KEY_W-1:0] data_q, data_d;
   logic [KEY_W-1:0] hit;
   logic             parity_q, parity_d;

   generate
      for (genvar i = 0; i < KEY_W; i++) begin : g_bit
         assign hit[i] = capture && (idx == IDX_W'(i));
      end
   endgenerate

   // Indices beyond the key (the parity bit) only feed the running parity.
   always_comb begin
      data_d   = (data_q & ~hit) | ({KEY_W{bit_in}} & hit);
      parity_d = capture ? (parity_q ^ bit_in) : parity_q;
      if (clear) begin
         data_d   = '0;
         parity_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q   <= '0;
         parity_q <= 1'b0;
      end else begin
         data_q   <= data_d;
         parity_q <= parity_d;
      end
   end

   assign data   = data_q;
   assign parity = parity_q;

endmodule

`default_nettype wire

// File: rtl/key_load_ctrl.sv
// ============================================================================
// key_load_ctrl : serial key load, parity check, atomic commit and lockout
// Rev 1.0
// ============================================================================
`default_nettype none

module key_load_ctrl
   import key_load_pkg::*;
#(
   parameter int KEY_W    = KEY_W_DEF,
   parameter int MAX_FAIL = 3,
   parameter int TIMEOUT  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_req,
   output logic             load_ack,
   input  logic             bit_valid,
   input  logic             bit_data,
   input  logic             load_abort,
   output logic             busy,
   output logic [KEY_W-1:0] key_out,
   output logic             key_ok,
   output logic             err,
   output logic             lockout,
   output logic [1:0]       fail_cnt
);

   localparam int FRAME_LEN = frame_len(KEY_W);
   localparam int CNT_W     = $clog2(FRAME_LEN);
   localparam int IDLE_W    = $clog2(TIMEOUT);

   state_e            state_q, state_d;
   logic [KEY_W-1:0]  key_out_q, key_out_d;
   logic              key_ok_q, key_ok_d;
   logic              err_q, err_d;
   logic              lockout_q, lockout_d;
   logic [1:0]        fail_cnt_q, fail_cnt_d;
   logic              load_ack_q, load_ack_d;
   logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;

   logic              sr_clear, sr_capture, sr_parity, fail;
   logic [KEY_W-1:0]  sr_data;
   logic [1:0]        fail_inc;

   key_shift_reg #(
      .KEY_W (KEY_W),
      .IDX_W (CNT_W)
   ) u_shift (
      .clk     (clk),
      .rst     (rst),
      .clear   (sr_clear),
      .capture (sr_capture),
      .idx     (bit_cnt_q),
      .bit_in  (bit_data),
      .data    (sr_data),
      .parity  (sr_parity)
   );

   always_comb begin
      state_d    = state_q;
      key_out_d  = key_out_q;
      key_ok_d   = key_ok_q;
      err_d      = err_q;
      lockout_d  = lockout_q;
      fail_cnt_d = fail_cnt_q;
      load_ack_d = 1'b0;
      bit_cnt_d  = bit_cnt_q;
      idle_cnt_d = idle_cnt_q;
      sr_clear   = 1'b0;
      sr_capture = 1'b0;
      fail       = 1'b0;
      fail_inc   = fail_cnt_q + 2'd1;

      case (state_q)
         ST_IDLE: begin
            if (load_req) begin
               load_ack_d = 1'b1;
               state_d    = ST_SHIFT;
               sr_clear   = 1'b1;
               bit_cnt_d  = '0;
               idle_cnt_d = '0;
               key_ok_d   = 1'b0;
               err_d      = 1'b0;
            end
         end
         ST_SHIFT: begin
            if (load_abort) begin
               state_d = ST_IDLE;
            end else if (bit_valid) begin
               sr_capture = 1'b1;
               idle_cnt_d = '0;
               if (bit_cnt_q == CNT_W'(FRAME_LEN - 1)) begin
                  state_d = ST_CHECK;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end else if (idle_cnt_q == IDLE_W'(TIMEOUT - 1)) begin
               fail = 1'b1;
            end else begin
               idle_cnt_d = idle_cnt_q + 1'b1;
            end
         end
         ST_CHECK: begin
            if (!sr_parity) begin
               key_out_d  = sr_data;
               key_ok_d   = 1'b1;
               fail_cnt_d = '0;
               state_d    = ST_IDLE;
            end else begin
               fail = 1'b1;
            end
         end
         ST_LOCKOUT: begin
            key_out_d = '0;
            key_ok_d  = 1'b0;
         end
         default: state_d = ST_IDLE;
      endcase

      // Parity and timeout failures share the same counting/lockout path.
      if (fail) begin
         err_d      = 1'b1;
         fail_cnt_d = fail_inc;
         if (fail_inc == 2'(MAX_FAIL)) begin
            state_d   = ST_LOCKOUT;
            lockout_d = 1'b1;
            key_out_d = '0;
            key_ok_d  = 1'b0;
         end else begin
            state_d = ST_IDLE;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         key_out_q  <= '0;
         key_ok_q   <= 1'b0;
         err_q      <= 1'b0;
         lockout_q  <= 1'b0;
         fail_cnt_q <= '0;
         load_ack_q <= 1'b0;
         bit_cnt_q  <= '0;
         idle_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         key_out_q  <= key_out_d;
         key_ok_q   <= key_ok_d;
         err_q      <= err_d;
         lockout_q  <= lockout_d;
         fail_cnt_q <= fail_cnt_d;
         load_ack_q <= load_ack_d;
         bit_cnt_q  <= bit_cnt_d;
         idle_cnt_q <= idle_cnt_d;
      end
   end

   assign load_ack = load_ack_q;
   assign busy     = (state_q == ST_SHIFT) || (state_q == ST_CHECK);
   assign key_out  = key_out_q;
   assign key_ok   = key_ok_q;
   assign err      = err_q;
   assign lockout  = lockout_q;
   assign fail_cnt = fail_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_key_load_ctrl.sv
// ============================================================================
// tb_key_load_ctrl : directed self-checking bench for key_load_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_key_load_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        load_req, bit_valid, bit_data, load_abort;
   logic        load_ack, busy, key_ok, err, lockout;
   logic [11:0] key_out;
   logic [1:0]  fail_cnt;

   int checks = 0;
   int errors = 0;

   key_load_ctrl #(
      .KEY_W    (12),
      .MAX_FAIL (3),
      .TIMEOUT  (16)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .load_req   (load_req),
      .load_ack   (load_ack),
      .bit_valid  (bit_valid),
      .bit_data   (bit_data),
      .load_abort (load_abort),
      .busy       (busy),
      .key_out    (key_out),
      .key_ok     (key_ok),
      .err        (err),
      .lockout    (lockout),
      .fail_cnt   (fail_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_load();
      load_req = 1'b1;
      tick();
      load_req = 1'b0;
   endtask

   task automatic send_bit(input logic b);
      bit_valid = 1'b1;
      bit_data  = b;
      tick();
      bit_valid = 1'b0;
      bit_data  = 1'b0;
   endtask

   // Sends key LSB first plus parity, then lets the CHECK cycle complete.
   task automatic send_frame(input logic [11:0] key, input logic par);
      for (int i = 0; i < 12; i++) send_bit(key[i]);
      send_bit(par);
      tick();
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_key_out"},  32'(key_out),  32'h0);
      chk({tag, "_key_ok"},   32'(key_ok),   32'h0);
      chk({tag, "_err"},      32'(err),      32'h0);
      chk({tag, "_lockout"},  32'(lockout),  32'h0);
      chk({tag, "_fail_cnt"}, 32'(fail_cnt), 32'h0);
      chk({tag, "_ack"},      32'(load_ack), 32'h0);
      chk({tag, "_busy"},     32'(busy),     32'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [11:0] k;
      rst = 1'b1; load_req = 1'b0; bit_valid = 1'b0; bit_data = 1'b0; load_abort = 1'b0;
      #12;
      chk_all_zero("reset");
      rst = 1'b0;
      tick();

      // Good load 0xA5C, even parity bit 0
      k = 12'hA5C;
      start_load();
      chk("ack_pulse", 32'(load_ack), 32'h1);
      chk("busy_shift", 32'(busy), 32'h1);
      send_bit(k[0]);
      chk("ack_one_cycle", 32'(load_ack), 32'h0);
      for (int i = 1; i < 12; i++) send_bit(k[i]);
      send_bit(1'b0);
      chk("check_state_key_ok", 32'(key_ok), 32'h0);
      chk("check_state_busy", 32'(busy), 32'h1);
      tick();
      chk("good_key_out", 32'(key_out), 32'hA5C);
      chk("good_key_ok", 32'(key_ok), 32'h1);
      chk("good_busy", 32'(busy), 32'h0);

      // Same key, wrong parity
      start_load();
      chk("reload_key_ok_clr", 32'(key_ok), 32'h0);
      chk("reload_key_hold", 32'(key_out), 32'hA5C);
      send_frame(12'hA5C, 1'b1);
      chk("par1_err", 32'(err), 32'h1);
      chk("par1_key_ok", 32'(key_ok), 32'h0);
      chk("par1_key_out", 32'(key_out), 32'hA5C);
      chk("par1_fail_cnt", 32'(fail_cnt), 32'h1);

      start_load();
      chk("reload_err_clr", 32'(err), 32'h0);
      send_frame(12'hA5C, 1'b1);
      chk("par2_fail_cnt", 32'(fail_cnt), 32'h2);
      chk("par2_lockout", 32'(lockout), 32'h0);

      start_load();
      send_frame(12'hA5C, 1'b1);
      chk("par3_lockout", 32'(lockout), 32'h1);
      chk("par3_key_out", 32'(key_out), 32'h0);
      chk("par3_fail_cnt", 32'(fail_cnt), 32'h3);
      chk("par3_busy", 32'(busy), 32'h0);

      load_req = 1'b1;
      tick();
      chk("lock_no_ack", 32'(load_ack), 32'h0);
      tick();
      chk("lock_no_ack2", 32'(load_ack), 32'h0);
      chk("lock_no_busy", 32'(busy), 32'h0);
      load_req = 1'b0;

      // Async reset out of lockout
      rst = 1'b1;
      #1;
      chk_all_zero("rst_lock");
      #2;
      rst = 1'b0;
      tick();

      // Timeout after 5 bits
      start_load();
      for (int i = 0; i < 5; i++) send_bit(1'b1);
      for (int i = 0; i < 15; i++) tick();
      chk("to_pre_busy", 32'(busy), 32'h1);
      chk("to_pre_err", 32'(err), 32'h0);
      tick();
      chk("to_err", 32'(err), 32'h1);
      chk("to_busy", 32'(busy), 32'h0);
      chk("to_fail_cnt", 32'(fail_cnt), 32'h1);
      chk("to_key_ok", 32'(key_ok), 32'h0);

      // Next good load (0x3C3, parity 0) clears the failure count
      start_load();
      send_frame(12'h3C3, 1'b0);
      chk("recov_key_out", 32'(key_out), 32'h3C3);
      chk("recov_fail_cnt", 32'(fail_cnt), 32'h0);
      chk("recov_key_ok", 32'(key_ok), 32'h1);

      // One failure, then abort colliding with bit_valid
      start_load();
      send_frame(12'h3C3, 1'b1);
      chk("pre_abort_fail_cnt", 32'(fail_cnt), 32'h1);
      start_load();
      for (int i = 0; i < 4; i++) send_bit(1'b0);
      load_abort = 1'b1;
      send_bit(1'b1);
      load_abort = 1'b0;
      chk("abort_busy", 32'(busy), 32'h0);
      chk("abort_fail_cnt", 32'(fail_cnt), 32'h1);
      chk("abort_key_ok", 32'(key_ok), 32'h0);
      chk("abort_err", 32'(err), 32'h0);
      chk("abort_key_out", 32'(key_out), 32'h3C3);
      for (int i = 0; i < 3; i++) send_bit(1'b1);
      chk("abort_stays_idle", 32'(busy), 32'h0);

      // Async reset mid-SHIFT, then fresh load 0x001 with parity 1
      start_load();
      for (int i = 0; i < 3; i++) send_bit(1'b1);
      rst = 1'b1;
      #1;
      chk_all_zero("rst_shift");
      #2;
      rst = 1'b0;
      tick();
      start_load();
      send_frame(12'h001, 1'b1);
      chk("fresh_key_out", 32'(key_out), 32'h001);
      chk("fresh_key_ok", 32'(key_ok), 32'h1);
      chk("fresh_err", 32'(err), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
